// File: rtl/icache_prefetch_gen_pkg.sv
// Shared types and constants for the instruction-cache next-line prefetcher.
package toy_pack;

  localparam int ICACHE_REQ_ADDR_WIDTH    = 33;
  localparam int ICACHE_REQ_OPCODE_WIDTH  = 3;
  localparam int ICACHE_LINE_OFFSET_WIDTH = 6;
  localparam int ICACHE_PAGE_OFFSET_WIDTH = 12;
  localparam int ICACHE_PF_FIFO_DEPTH     = 4;
  localparam int ICACHE_PF_CNT_WIDTH      = $clog2(ICACHE_PF_FIFO_DEPTH + 1);

  typedef logic [ICACHE_REQ_ADDR_WIDTH-1:0] req_addr_t;

  localparam logic [ICACHE_REQ_OPCODE_WIDTH-1:0] ICACHE_OPCODE_PREFETCH = 3'd2;
  localparam req_addr_t ICACHE_LINE_BYTES = req_addr_t'(1) << ICACHE_LINE_OFFSET_WIDTH;

  // Generator FSM encoding
  localparam logic [0:0] PF_ST_IDLE = 1'b0;
  localparam logic [0:0] PF_ST_GEN  = 1'b1;

  // Internal state exported for observation
  typedef struct packed {
    logic [0:0]                     state;
    logic [1:0]                     remain;
    logic [ICACHE_PF_CNT_WIDTH-1:0] fifo_count;
    logic                           last_valid;
  } pf_dbg_t;

  // Clear the byte-in-line offset bits
  function automatic req_addr_t line_align(input req_addr_t a);
    return {a[ICACHE_REQ_ADDR_WIDTH-1:ICACHE_LINE_OFFSET_WIDTH],
            {ICACHE_LINE_OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_prefetch_gen_if.sv
// Trigger and prefetch-request bundle of the next-line prefetcher.
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where vld and rdy are both 1; a producer holding vld=1 keeps its payload
// stable until that edge, and rdy may depend combinationally on the state.
interface icache_prefetch_gen_if;
  import toy_pack::*;

  logic                               pf_en;
  logic [1:0]                         pf_degree;
  logic                               trig_vld;
  logic                               trig_rdy;
  req_addr_t                          trig_addr;
  logic                               pf_flush;
  logic                               prefetch_req_vld;
  logic                               prefetch_req_rdy;
  logic [ICACHE_REQ_OPCODE_WIDTH-1:0] prefetch_req_opcode;
  req_addr_t                          prefetch_req_addr;

  // Prefetcher side
  modport master (
    input  pf_en, pf_degree, trig_vld, trig_addr, pf_flush, prefetch_req_rdy,
    output trig_rdy, prefetch_req_vld, prefetch_req_opcode, prefetch_req_addr
  );

  // Cache controller / arbiter side
  modport slave (
    output pf_en, pf_degree, trig_vld, trig_addr, pf_flush, prefetch_req_rdy,
    input  trig_rdy, prefetch_req_vld, prefetch_req_opcode, prefetch_req_addr
  );
endinterface

// File: rtl/icache_prefetch_gen_fifo.sv
// Small circular FIFO holding pending prefetch line addresses.
// Full/empty come from the registered count only, so a pop in the same
// cycle never frees space for a push.
module icache_pf_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; flush overrides push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/icache_prefetch_gen.sv
// Next-line instruction prefetcher: a demand-miss trigger spawns up to three
// sequential line prefetches, staying inside the 4 KB page of the miss and
// skipping a line identical to the previously generated one.
module icache_prefetch_gen
  import toy_pack::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  icache_prefetch_gen_if.master       bus,
  output pf_dbg_t                     dbg
);
  logic [0:0]                     state;
  req_addr_t                      cur_line;
  req_addr_t                      last_line;
  logic                           last_valid;
  logic [1:0]                     remain;
  logic                           active;
  logic                           trig_hs;
  logic                           page_cross;
  logic                           push;
  logic                           fifo_empty;
  logic                           fifo_full;
  logic [ICACHE_PF_CNT_WIDTH-1:0] fifo_count;

  // active holds trig_rdy low until the first edge after reset release
  assign bus.trig_rdy = active & (state == PF_ST_IDLE) & bus.pf_en & ~bus.pf_flush;
  assign trig_hs      = bus.trig_vld & bus.trig_rdy;
  assign page_cross   = (cur_line[ICACHE_PAGE_OFFSET_WIDTH-1:ICACHE_LINE_OFFSET_WIDTH] == '0);

  assign bus.prefetch_req_vld    = ~fifo_empty;
  assign bus.prefetch_req_opcode = ICACHE_OPCODE_PREFETCH;

  assign dbg = '{state: state, remain: remain, fifo_count: fifo_count, last_valid: last_valid};

  // Push the current line unless it duplicates the last generated line
  always_comb begin
    push = 1'b0;
    if (state == PF_ST_GEN && !bus.pf_flush && !page_cross && !fifo_full)
      push = !(last_valid && (cur_line == last_line));
  end

  // Generator FSM; flush aborts everything and forgets the dedup history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PF_ST_IDLE;
      cur_line   <= '0;
      last_line  <= '0;
      last_valid <= 1'b0;
      remain     <= '0;
      active     <= 1'b0;
    end else begin
      active <= 1'b1;
      if (bus.pf_flush) begin
        state      <= PF_ST_IDLE;
        last_valid <= 1'b0;
        remain     <= '0;
      end else begin
        case (state)
          PF_ST_IDLE: begin
            if (trig_hs && bus.pf_degree != 2'd0) begin
              cur_line <= line_align(bus.trig_addr) + ICACHE_LINE_BYTES;
              remain   <= bus.pf_degree;
              state    <= PF_ST_GEN;
            end
          end
          PF_ST_GEN: begin
            if (page_cross) begin
              state  <= PF_ST_IDLE;
              remain <= '0;
            end else if (!fifo_full) begin
              last_line  <= cur_line;
              last_valid <= 1'b1;
              cur_line   <= cur_line + ICACHE_LINE_BYTES;
              remain     <= remain - 2'd1;
              if (remain == 2'd1) state <= PF_ST_IDLE;
            end
          end
          default: state <= PF_ST_IDLE;
        endcase
      end
    end
  end

  icache_pf_fifo #(
    .WIDTH (ICACHE_REQ_ADDR_WIDTH),
    .DEPTH (ICACHE_PF_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (cur_line),
    .pop       (bus.prefetch_req_vld & bus.prefetch_req_rdy),
    .flush     (bus.pf_flush),
    .head      (bus.prefetch_req_addr),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_icache_prefetch_gen.sv
// Directed bench for the next-line prefetcher.
module tb_icache_prefetch_gen;
  import toy_pack::*;

  logic    clk;
  logic    rst_n;
  pf_dbg_t dbg;
  int      n_checks;
  int      n_fails;
  logic [ICACHE_REQ_ADDR_WIDTH-1:0] exp_q[$];

  icache_prefetch_gen_if bus ();

  icache_prefetch_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .dbg   (dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_trig(input logic [1:0] degree, input req_addr_t addr);
    bus.pf_degree = degree;
    bus.trig_addr = addr;
    bus.trig_vld  = 1'b1;
  endtask

  task automatic chk_req(input string tag, input logic vld, input req_addr_t addr);
    chk({tag, "_vld"}, bus.prefetch_req_vld, vld);
    if (vld) chk({tag, "_addr"}, bus.prefetch_req_addr, addr);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0;
    bus.pf_en = 1'b1;
    bus.pf_degree = 2'd0;
    bus.trig_vld = 1'b0;
    bus.trig_addr = '0;
    bus.pf_flush = 1'b0;
    bus.prefetch_req_rdy = 1'b0;

    // reset state
    #2;
    chk("rst_vld", bus.prefetch_req_vld, 1'b0);
    chk("rst_addr", bus.prefetch_req_addr, 33'h0);
    chk("rst_trig_rdy", bus.trig_rdy, 1'b0);
    chk("rst_state", dbg.state, PF_ST_IDLE);
    chk("rst_count", dbg.fifo_count, 0);
    chk("opcode", bus.prefetch_req_opcode, 3'd2);
    #6;
    rst_n = 1'b1;
    #1;
    chk("rel_trig_rdy_early", bus.trig_rdy, 1'b0);
    tick();
    chk("rel_trig_rdy", bus.trig_rdy, 1'b1);

    // degree 2 from 0x1040: 0x1080 then 0x10C0
    bus.prefetch_req_rdy = 1'b1;
    send_trig(2'd2, 33'h0_0000_1040);
    tick();
    bus.trig_vld = 1'b0;
    chk("t1_c1_state", dbg.state, PF_ST_GEN);
    chk("t1_c1_vld", bus.prefetch_req_vld, 1'b0);
    tick();
    chk_req("t1_c2", 1'b1, 33'h1080);
    tick();
    chk_req("t1_c3", 1'b1, 33'h10C0);
    chk("t1_c3_state", dbg.state, PF_ST_IDLE);
    tick();
    chk_req("t1_c4", 1'b0, '0);

    // enable gating, then page-crossing trigger
    bus.pf_en = 1'b0;
    #1;
    chk("t2_en0_trig_rdy", bus.trig_rdy, 1'b0);
    bus.pf_en = 1'b1;
    #1;
    chk("t2_en1_trig_rdy", bus.trig_rdy, 1'b1);
    send_trig(2'd3, 33'h0FC0);
    tick();
    bus.trig_vld = 1'b0;
    chk("t2_c1_state", dbg.state, PF_ST_GEN);
    tick();
    chk("t2_c2_state", dbg.state, PF_ST_IDLE);
    chk_req("t2_c2", 1'b0, '0);
    tick();
    chk_req("t2_c3", 1'b0, '0);
    chk("t2_c3_count", dbg.fifo_count, 0);

    // back-pressure: two degree-3 triggers fill the FIFO and stall GEN
    bus.prefetch_req_rdy = 1'b0;
    exp_q = {33'h2040, 33'h2080, 33'h20C0, 33'h3040, 33'h3080, 33'h30C0};
    send_trig(2'd3, 33'h2000);
    tick();
    bus.trig_vld = 1'b0;
    tick();
    tick();
    tick();
    chk("t3_c4_state", dbg.state, PF_ST_IDLE);
    chk("t3_c4_count", dbg.fifo_count, 3);
    chk_req("t3_c4", 1'b1, 33'h2040);
    send_trig(2'd3, 33'h3000);
    #1;
    chk("t3_c4_trig_rdy", bus.trig_rdy, 1'b1);
    tick();
    bus.trig_vld = 1'b0;
    tick();
    chk("t3_c6_count", dbg.fifo_count, 4);
    chk("t3_c6_state", dbg.state, PF_ST_GEN);
    chk("t3_c6_remain", dbg.remain, 2);
    tick();
    chk("t3_c7_count", dbg.fifo_count, 4);
    chk("t3_c7_remain", dbg.remain, 2);
    chk_req("t3_c7_hold", 1'b1, 33'h2040);
    bus.prefetch_req_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("t3_drain_vld", bus.prefetch_req_vld, 1'b1);
      chk("t3_drain_addr", bus.prefetch_req_addr, exp_q.pop_front());
      tick();
    end
    chk_req("t3_end", 1'b0, '0);
    chk("t3_end_state", dbg.state, PF_ST_IDLE);
    chk("t3_q_empty", exp_q.size(), 0);

    // dedup: the same trigger twice issues one prefetch
    send_trig(2'd1, 33'h4000);
    tick();
    bus.trig_vld = 1'b0;
    chk("t4_c1_state", dbg.state, PF_ST_GEN);
    tick();
    chk_req("t4_c2", 1'b1, 33'h4040);
    chk("t4_c2_state", dbg.state, PF_ST_IDLE);
    send_trig(2'd1, 33'h4000);
    tick();
    bus.trig_vld = 1'b0;
    chk("t4_c3_state", dbg.state, PF_ST_GEN);
    chk_req("t4_c3", 1'b0, '0);
    tick();
    chk("t4_c4_state", dbg.state, PF_ST_IDLE);
    chk_req("t4_c4", 1'b0, '0);
    tick();
    chk_req("t4_c5", 1'b0, '0);

    // flush mid-GEN with three entries queued
    bus.prefetch_req_rdy = 1'b0;
    send_trig(2'd1, 33'h5000);
    tick();
    bus.trig_vld = 1'b0;
    tick();
    chk("t5_pre_count", dbg.fifo_count, 1);
    send_trig(2'd3, 33'h6000);
    tick();
    bus.trig_vld = 1'b0;
    tick();
    tick();
    chk("t5_c5_state", dbg.state, PF_ST_GEN);
    chk("t5_c5_count", dbg.fifo_count, 3);
    chk("t5_c5_remain", dbg.remain, 1);
    bus.pf_flush = 1'b1;
    bus.prefetch_req_rdy = 1'b1;
    tick();
    bus.pf_flush = 1'b0;
    chk_req("t5_c6", 1'b0, '0);
    chk("t5_c6_state", dbg.state, PF_ST_IDLE);
    chk("t5_c6_count", dbg.fifo_count, 0);
    chk("t5_c6_last_valid", dbg.last_valid, 1'b0);
    #1;
    chk("t5_c6_trig_rdy", bus.trig_rdy, 1'b1);
    bus.pf_flush = 1'b1;
    #1;
    chk("t5_flush_trig_rdy", bus.trig_rdy, 1'b0);
    bus.pf_flush = 1'b0;
    send_trig(2'd1, 33'h6040);
    tick();
    bus.trig_vld = 1'b0;
    tick();
    chk_req("t5_c8", 1'b1, 33'h6080);
    tick();
    chk_req("t5_c9", 1'b0, '0);

    // pf_en drop does not abort GEN; asynchronous reset mid-GEN
    bus.prefetch_req_rdy = 1'b0;
    send_trig(2'd3, 33'h7000);
    tick();
    bus.trig_vld = 1'b0;
    bus.pf_en = 1'b0;
    tick();
    chk("t6_c2_state", dbg.state, PF_ST_GEN);
    chk_req("t6_c2", 1'b1, 33'h7040);
    bus.pf_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", bus.prefetch_req_vld, 1'b0);
    chk("t6_rst_addr", bus.prefetch_req_addr, 33'h0);
    chk("t6_rst_trig_rdy", bus.trig_rdy, 1'b0);
    chk("t6_rst_state", dbg.state, PF_ST_IDLE);
    chk("t6_rst_count", dbg.fifo_count, 0);
    chk("t6_rst_remain", dbg.remain, 0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("t6_rel_trig_rdy_early", bus.trig_rdy, 1'b0);
    tick();
    chk("t6_rel_trig_rdy", bus.trig_rdy, 1'b1);
    bus.prefetch_req_rdy = 1'b1;
    send_trig(2'd1, 33'h8000);
    tick();
    bus.trig_vld = 1'b0;
    tick();
    chk_req("t6_post", 1'b1, 33'h8040);
    tick();
    chk_req("t6_post_end", 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/icache_prefetch_gen.md
ICACHE_PREFETCH_GEN -- requirements
Module: icache_prefetch_gen

Interface
REQ-001 The block SHALL have port `clk`, input, 1 bit: the single clock.
REQ-002 The block SHALL have port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have port `pf_en`, input, 1 bit: prefetch enable; 0 blocks new triggers.
REQ-004 The block SHALL have port `pf_degree`, input, 2 bits: number of next lines per trigger (0 = none, 1..3).
REQ-005 The block SHALL have port `trig_vld`, input, 1 bit: demand-miss trigger valid.
REQ-006 The block SHALL have port `trig_rdy`, output, 1 bit: trigger accepted.
REQ-007 The block SHALL have port `trig_addr`, input, req_addr_t (33 bits): miss address.
REQ-008 The block SHALL have port `pf_flush`, input, 1 bit: discard all pending prefetches.
REQ-009 The block SHALL have port `prefetch_req_vld`, output, 1 bit: request to the request arbiter.
REQ-010 The block SHALL have port `prefetch_req_rdy`, input, 1 bit: arbiter grant.
REQ-011 The block SHALL have port `prefetch_req_opcode`, output, ICACHE_REQ_OPCODE_WIDTH: constant ICACHE_OPCODE_PREFETCH.
REQ-012 The block SHALL have port `prefetch_req_addr`, output, req_addr_t: line-aligned prefetch address.

Function
REQ-013 The block SHALL have states IDLE and GEN.
REQ-014 `trig_rdy` SHALL be 1 only in IDLE with `pf_en`=1 and `pf_flush`=0.
REQ-015 On trigger handshake with `pf_degree`!=0: latch `cur_line` = trig_addr line-aligned (ICACHE_LINE_OFFSET_WIDTH=6 LSBs zeroed) plus one line; latch `remain` = `pf_degree`; enter GEN.
REQ-016 On trigger handshake with `pf_degree`=0, the block SHALL stay in IDLE with no effect.
REQ-017 In GEN, each cycle with FIFO not full: push `cur_line` unless it equals `last_line` while `last_valid`=1 (dedup skip); update `last_line`; `cur_line` += 64; `remain` -= 1.
REQ-018 In GEN with FIFO full, the block SHALL stall and SHALL NOT drop or decrement.
REQ-019 The FIFO full test SHALL use the registered count only (no same-cycle pop bypass).
REQ-020 GEN SHALL exit to IDLE after the cycle in which `remain` reaches 0.
REQ-021 GEN SHALL exit to IDLE immediately, without pushing, when `cur_line` crosses a 4 KB page boundary (`cur_line[11:6]`==0).
- 33-bit arithmetic therefore never wraps.
REQ-022 The FIFO SHALL have 4 entries (ICACHE_PF_FIFO_DEPTH); `prefetch_req_vld` = !empty; `prefetch_req_addr` = head entry, registered, stable while vld=1 and rdy=0.
REQ-023 The FIFO SHALL pop on `prefetch_req_vld` & `prefetch_req_rdy`; simultaneous push and pop SHALL keep the count unchanged.
REQ-024 Latency SHALL be: trigger handshake in cycle 0 -> first push in cycle 1 -> `prefetch_req_vld`=1 in cycle 2.
REQ-025 `pf_flush` SHALL have priority over trigger, push and pop.
- Next cycle: FIFO empty, state IDLE, `last_valid`=0.
- A pop handshake in the flush cycle is still honoured by the arbiter; the entry is discarded.
REQ-026 `pf_en` deasserted during GEN SHALL NOT abort generation; only `pf_flush` aborts.

Reset
REQ-027 While `rst_n`=0, asynchronously: state IDLE, FIFO pointers and count 0, `last_valid`=0, `remain`=0, `prefetch_req_vld`=0, `prefetch_req_addr`=0, `trig_rdy`=0.
REQ-028 The first trigger SHALL be accepted no earlier than the first clock edge after reset release.

Structure
REQ-029 ICACHE_OPCODE_PREFETCH, ICACHE_LINE_OFFSET_WIDTH, ICACHE_PF_FIFO_DEPTH and req_addr_t SHALL reside in toy_pack.
REQ-030 The FIFO SHALL be a sub-module `icache_pf_fifo` (parameterised width/depth, push/pop/flush, count output).

Verification
REQ-031 degree=2, trig_addr=0x0_0000_1040, rdy=1 -> vld in cycle 2 with addr 0x1080, cycle 3 with 0x10C0; then IDLE.
REQ-032 degree=3, trig_addr=0xFC0 -> no push (0x1000 crosses page); GEN exits; vld stays 0.
REQ-033 rdy=0, two triggers (0x2000, then 0x3000) at degree=3 -> FIFO holds 4 entries, GEN stalls with remain=2; on rdy=1 the remaining 0x3080 and 0x30C0 follow in order; nothing dropped.
REQ-034 Trigger 0x4000 (degree 1), then 0x4000 again -> second 0x4040 is skipped by dedup; exactly one prefetch is issued.
REQ-035 pf_flush mid-GEN with 3 FIFO entries -> next cycle vld=0, IDLE, trig_rdy=1; a subsequent identical trigger is not deduped.
REQ-036 rst_n asserted mid-GEN (asynchronous) -> all outputs 0 in the same cycle; after release, normal operation resumes.
